operand_sequencer: RTL and testbench

Front-end controller of the 8-bit ALU board design. It turns a single bouncing push-button plus slide switches into a clean, staged capture of operand A, operand B and the opcode. It drives the bit-wise D flip-flop operand/opcode registers downstream via load strobes and held values, and flags when a complete operation is ready for the ALU and its display.

---
 rtl/operand_sequencer.sv | 144 ++++++++++++++
 tb/tb_operand_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// Front-end controller for the 8-bit ALU board: debounces one push-button and
// steps through operand A, operand B and opcode capture, flagging a complete operation.
module operand_sequencer #(
    parameter int WIDTH           = 8,
    parameter int OP_W            = 3,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [OP_W-1:0]  op_sw,
    input  logic             key_n,
    input  logic             restart,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [OP_W-1:0]  op_q,
    output logic             load_a,
    output logic             load_b,
    output logic             load_op,
    output logic             result_valid,
    output logic [1:0]       state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_nx;
    logic             key_meta;
    logic             key_s;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;
    logic             press;
    logic             cap_a;
    logic             cap_b;
    logic             cap_op;
    logic             leave_show;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_s    <= key_meta;
        end
    end

    // Any sample that agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
        end else begin
            stable_d <= stable;
            if (key_s != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= key_s;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = stable_d & ~stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_A;
        end else begin
            state_r <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state_r;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        cap_op     = 1'b0;
        leave_show = 1'b0;
        if (restart) begin
            state_nx = S_A;
        end else if (press) begin
            case (state_r)
                S_A: begin
                    cap_a    = 1'b1;
                    state_nx = S_B;
                end
                S_B: begin
                    cap_b    = 1'b1;
                    state_nx = S_OP;
                end
                S_OP: begin
                    cap_op   = 1'b1;
                    state_nx = S_SHOW;
                end
                default: begin
                    leave_show = 1'b1;
                    state_nx   = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            load_a       <= 1'b0;
            load_b       <= 1'b0;
            load_op      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            load_a  <= cap_a;
            load_b  <= cap_b;
            load_op <= cap_op;
            if (cap_a)  a_q  <= sw;
            if (cap_b)  b_q  <= sw;
            if (cap_op) op_q <= op_sw;
            if (restart || leave_show) begin
                result_valid <= 1'b0;
            end else if (cap_op) begin
                result_valid <= 1'b1;
            end
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed scenarios plus random key/switch traffic,
// checked every cycle against a sample-window reference model.
module tb_operand_sequencer;

    localparam int W  = 8;
    localparam int OW = 3;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  sw;
    logic [OW-1:0] op_sw;
    logic          key_n;
    logic          restart;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [OW-1:0] op_q;
    logic          load_a;
    logic          load_b;
    logic          load_op;
    logic          result_valid;
    logic [1:0]    state;

    operand_sequencer #(
        .WIDTH(W),
        .OP_W(OW),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw(sw),
        .op_sw(op_sw),
        .key_n(key_n),
        .restart(restart),
        .a_q(a_q),
        .b_q(b_q),
        .op_q(op_q),
        .load_a(load_a),
        .load_b(load_b),
        .load_op(load_op),
        .result_valid(result_valid),
        .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: key samples per edge; the level flips once the D samples taken
    // 2..D+1 edges ago all disagree with it, and a fall captures one edge later.
    int            hist[$];
    int            lvl;
    bit            pend;
    int            mstep;
    logic [W-1:0]  ma;
    logic [W-1:0]  mb;
    logic [OW-1:0] mop;
    bit            mrv;
    bit            mla;
    bit            mlb;
    bit            mlo;
    int            n_la;
    int            n_lb;
    int            n_lo;
    int            pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(1);
        lvl = 1; pend = 0; mstep = 0;
        ma = '0; mb = '0; mop = '0;
        mrv = 0; mla = 0; mlb = 0; mlo = 0;
    endtask

    task automatic model_edge();
        bit all;
        mla = 0; mlb = 0; mlo = 0;
        if (restart) begin
            mstep = 0;
            mrv   = 0;
        end else if (pend) begin
            case (mstep)
                0: begin ma  = sw;    mla = 1; mstep = 1; end
                1: begin mb  = sw;    mlb = 1; mstep = 2; end
                2: begin mop = op_sw; mlo = 1; mrv = 1; mstep = 3; end
                default: begin mrv = 0; mstep = 0; end
            endcase
        end
        hist.push_back(int'(key_n));
        void'(hist.pop_front());
        all = 1;
        for (int i = 0; i < D; i++) if (hist[i] == lvl) all = 0;
        pend = 0;
        if (all) begin
            lvl  = 1 - lvl;
            pend = (lvl == 0);
        end
    endtask

    task automatic check_all();
        chk("a_q",    32'(a_q),          32'(ma));
        chk("b_q",    32'(b_q),          32'(mb));
        chk("op_q",   32'(op_q),         32'(mop));
        chk("state",  32'(state),        32'(mstep));
        chk("valid",  32'(result_valid), 32'(mrv));
        chk("load_a", 32'(load_a),       32'(mla));
        chk("load_b", 32'(load_b),       32'(mlb));
        chk("load_op",32'(load_op),      32'(mlo));
    endtask

    task automatic step(input bit k, input bit r);
        key_n   = k;
        restart = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        n_la += int'(load_a);
        n_lb += int'(load_b);
        n_lo += int'(load_op);
    endtask

    // Holds the key low for 8 edges then high for 8; pos = edge index of any load pulse.
    task automatic press_key();
        pos = -1;
        for (int i = 0; i < 8; i++) begin
            step(0, 0);
            if ((load_a | load_b | load_op) && pos < 0) pos = i;
        end
        for (int i = 0; i < 8; i++) step(1, 0);
    endtask

    task automatic clear_counts();
        n_la = 0; n_lb = 0; n_lo = 0;
    endtask

    initial begin
        reset_n = 1'b0; key_n = 1'b1; restart = 1'b0; sw = '0; op_sw = '0;
        clear_counts();
        model_reset();
        #2;
        check_all();
        #10 reset_n = 1'b1;

        // Full A/B/opcode sequence
        sw = 8'h3C; press_key(); chk("pos_a",  32'(pos), 32'd6);
        sw = 8'hA5; press_key(); chk("pos_b",  32'(pos), 32'd6);
        op_sw = 3'b101; press_key(); chk("pos_op", 32'(pos), 32'd6);
        chk("seq_a",  32'(a_q),  32'h3C);
        chk("seq_b",  32'(b_q),  32'hA5);
        chk("seq_op", 32'(op_q), 32'd5);
        chk("seq_st", 32'(state), 32'd3);
        chk("seq_rv", 32'(result_valid), 32'd1);

        // Bounce rejection from S_A
        step(1, 1);
        clear_counts();
        sw = 8'h11;
        for (int n = 0; n < 10; n++) begin
            step(0, 0); step(0, 0); step(0, 0); step(1, 0);
        end
        for (int i = 0; i < 6; i++) step(1, 0);
        chk("bounce_loads", 32'(n_la + n_lb + n_lo), 32'd0);
        chk("bounce_st",    32'(state), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0);
        for (int i = 0; i < 8; i++) step(1, 0);
        chk("bounce_one_a", 32'(n_la), 32'd1);

        // Long hold gives exactly one advance
        step(1, 1);
        clear_counts();
        sw = 8'h5A;
        for (int i = 0; i < 100; i++) step(0, 0);
        chk("hold_st", 32'(state), 32'd1);
        chk("hold_la", 32'(n_la + n_lb + n_lo), 32'd1);
        for (int i = 0; i < 8; i++) step(1, 0);
        sw = 8'hC3;
        press_key();
        chk("hold_st2", 32'(state), 32'd2);

        // restart on the press cycle in S_OP
        clear_counts();
        op_sw = 3'b010;
        for (int i = 0; i < 6; i++) step(0, 0);
        step(0, 1);
        for (int i = 0; i < 8; i++) step(1, 0);
        chk("rst_pri_st", 32'(state), 32'd0);
        chk("rst_pri_op", 32'(op_q), 32'd5);
        chk("rst_pri_lo", 32'(n_lo), 32'd0);
        chk("rst_pri_rv", 32'(result_valid), 32'd0);

        // Reset during a debounce in progress
        sw = 8'h77; press_key();
        step(0, 0); step(0, 0); step(0, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_a_zero", 32'(a_q), 32'd0);
        #2 reset_n = 1'b1;
        sw = 8'h96;
        pos = -1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0);
            if (load_a && pos < 0) pos = i;
        end
        chk("rst_fresh_pos", 32'(pos), 32'd6);
        for (int i = 0; i < 8; i++) step(1, 0);

        // Random traffic
        for (int seg = 0; seg < 150; seg++) begin
            bit k;
            int len;
            k   = bit'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) begin
                sw    = W'($urandom);
                op_sw = OW'($urandom);
                step(k, ($urandom_range(0, 40) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
